// File: rtl/jump_path_if.sv
// Bundles the controller-facing jump signals: start/geometry in, position/plot/busy/done out.
interface jump_path_if;
  logic       start;
  logic [7:0] c_x;
  logic [6:0] c_y;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, c_x, c_y, e_x, e_y,
    input  x_out, y_out, plot, busy, done
  );

  modport slave (
    input  start, c_x, c_y, e_x, e_y,
    output x_out, y_out, plot, busy, done
  );
endinterface

// File: rtl/jump_path.sv
// Sprite jump animator: up-right to the apex, down-right back to ground, one plot per step.
// Latency: first plot the cycle after start, then one step every STEP_DIV cycles; done follows landing.
// No backpressure: start is ignored unless idle. JUMP_PATH_HANG_EN adds HANG_TICKS apex hold steps.
module jump_path #(
  parameter int STEP_DIV   = 833333,
  parameter int X_MAX      = 159,
  parameter int HANG_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  jump_path_if.slave  jp
);

  localparam int             CW        = $clog2(STEP_DIV);
  localparam logic [CW-1:0]  STEP_LAST = CW'(STEP_DIV - 1);
  localparam logic [7:0]     X_LIM     = 8'(X_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RISE,
`ifdef JUMP_PATH_HANG_EN
    S_HANG,
`endif
    S_FALL,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    apex;
  logic [6:0]    ground;

  logic          step;
  logic [CW-1:0] cnt_next;
  logic [7:0]    x_step;
  logic [6:0]    y_up;
  logic [6:0]    y_dn;

  assign step     = (cnt == STEP_LAST);
  assign cnt_next = step ? '0 : cnt + CW'(1);
  assign x_step   = (jp.x_out >= X_LIM) ? jp.x_out : jp.x_out + 8'd1;
  assign y_up     = jp.y_out - 7'd1;
  assign y_dn     = jp.y_out + 7'd1;

`ifdef JUMP_PATH_HANG_EN
  localparam int             HW        = (HANG_TICKS > 1) ? $clog2(HANG_TICKS) : 1;
  localparam logic [HW-1:0]  HANG_LAST = HW'(HANG_TICKS - 1);
  logic [HW-1:0] hang_cnt;
  logic          unused_ok;
  assign unused_ok = ^jp.e_x;
`else
  logic          unused_ok;
  assign unused_ok = ^{jp.e_x, (HANG_TICKS != 0)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      apex      <= '0;
      ground    <= '0;
      jp.x_out  <= '0;
      jp.y_out  <= '0;
      jp.plot   <= 1'b0;
      jp.busy   <= 1'b0;
      jp.done   <= 1'b0;
`ifdef JUMP_PATH_HANG_EN
      hang_cnt  <= '0;
`endif
    end else begin
      jp.plot <= 1'b0;
      jp.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (jp.start) begin
            jp.x_out <= jp.c_x;
            jp.y_out <= jp.c_y;
            ground   <= jp.c_y;
            // An apex below ground means the upstream subtraction wrapped: jump to the top row.
            apex     <= (jp.e_y > jp.c_y) ? 7'd0 : jp.e_y;
            jp.busy  <= 1'b1;
            jp.plot  <= 1'b1;
            cnt      <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (apex == ground) begin
            jp.busy <= 1'b0;
            jp.done <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt   <= cnt_next;
            state <= S_RISE;
          end
        end
        S_RISE: begin
          cnt <= cnt_next;
          if (step) begin
            jp.x_out <= x_step;
            jp.y_out <= y_up;
            jp.plot  <= 1'b1;
            if (y_up == apex) begin
`ifdef JUMP_PATH_HANG_EN
              hang_cnt <= '0;
              state    <= S_HANG;
`else
              state    <= S_FALL;
`endif
            end
          end
        end
`ifdef JUMP_PATH_HANG_EN
        S_HANG: begin
          cnt <= cnt_next;
          if (step) begin
            if (hang_cnt == HANG_LAST) state <= S_FALL;
            else                       hang_cnt <= hang_cnt + HW'(1);
          end
        end
`endif
        S_FALL: begin
          cnt <= cnt_next;
          if (step) begin
            jp.x_out <= x_step;
            jp.y_out <= y_dn;
            jp.plot  <= 1'b1;
            if (y_dn == ground) state <= S_DONE;
          end
        end
        // Landing position is on screen this cycle; done is raised for the next one.
        S_DONE: begin
          jp.busy <= 1'b0;
          jp.done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
